// File: rtl/axi_bus_arbiter.sv
// Two-master / one-slave AXI4 arbiter: one transaction in flight,
// round-robin grant, combinational channel pass-through for the owner.
module axi_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                m0_arvalid,
    output logic                m0_arready,
    input  logic [ADDR_W-1:0]   m0_araddr,
    input  logic [3:0]          m0_arid,
    input  logic [7:0]          m0_arlen,
    input  logic [2:0]          m0_arsize,
    input  logic [1:0]          m0_arburst,
    output logic                m0_rvalid,
    input  logic                m0_rready,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic [1:0]          m0_rresp,
    output logic                m0_rlast,
    output logic [3:0]          m0_rid,
    input  logic                m0_awvalid,
    output logic                m0_awready,
    input  logic [ADDR_W-1:0]   m0_awaddr,
    input  logic [3:0]          m0_awid,
    input  logic [7:0]          m0_awlen,
    input  logic [2:0]          m0_awsize,
    input  logic [1:0]          m0_awburst,
    input  logic                m0_wvalid,
    output logic                m0_wready,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    input  logic                m0_wlast,
    output logic                m0_bvalid,
    input  logic                m0_bready,
    output logic [1:0]          m0_bresp,
    output logic [3:0]          m0_bid,
    input  logic                m1_arvalid,
    output logic                m1_arready,
    input  logic [ADDR_W-1:0]   m1_araddr,
    input  logic [3:0]          m1_arid,
    input  logic [7:0]          m1_arlen,
    input  logic [2:0]          m1_arsize,
    input  logic [1:0]          m1_arburst,
    output logic                m1_rvalid,
    input  logic                m1_rready,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic [1:0]          m1_rresp,
    output logic                m1_rlast,
    output logic [3:0]          m1_rid,
    input  logic                m1_awvalid,
    output logic                m1_awready,
    input  logic [ADDR_W-1:0]   m1_awaddr,
    input  logic [3:0]          m1_awid,
    input  logic [7:0]          m1_awlen,
    input  logic [2:0]          m1_awsize,
    input  logic [1:0]          m1_awburst,
    input  logic                m1_wvalid,
    output logic                m1_wready,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    input  logic                m1_wlast,
    output logic                m1_bvalid,
    input  logic                m1_bready,
    output logic [1:0]          m1_bresp,
    output logic [3:0]          m1_bid,
    output logic                s_arvalid,
    input  logic                s_arready,
    output logic [ADDR_W-1:0]   s_araddr,
    output logic [3:0]          s_arid,
    output logic [7:0]          s_arlen,
    output logic [2:0]          s_arsize,
    output logic [1:0]          s_arburst,
    input  logic                s_rvalid,
    output logic                s_rready,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic [1:0]          s_rresp,
    input  logic                s_rlast,
    input  logic [3:0]          s_rid,
    output logic                s_awvalid,
    input  logic                s_awready,
    output logic [ADDR_W-1:0]   s_awaddr,
    output logic [3:0]          s_awid,
    output logic [7:0]          s_awlen,
    output logic [2:0]          s_awsize,
    output logic [1:0]          s_awburst,
    output logic                s_wvalid,
    input  logic                s_wready,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    output logic                s_wlast,
    input  logic                s_bvalid,
    output logic                s_bready,
    input  logic [1:0]          s_bresp,
    input  logic [3:0]          s_bid,
    output logic                o_busy,
    output logic                o_owner,
    output logic                o_timeout
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE, RD_A, RD_D, WR_A, WR_B
    } state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          aw_done_q, aw_done_d;
    logic          w_done_q, w_done_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          tmo_q, tmo_d;

    logic rd_a, rd_d, wr_a, wr_b;
    logic req0, req1, win;
    logic ar_hs, r_hs, aw_hs, w_hs, b_hs, evt;
    logic aw_ok, w_ok;

    assign rd_a = (state_q == RD_A);
    assign rd_d = (state_q == RD_D);
    assign wr_a = (state_q == WR_A);
    assign wr_b = (state_q == WR_B);

    assign req0 = m0_arvalid | m0_awvalid;
    assign req1 = m1_arvalid | m1_awvalid;

    // Payload is muxed by owner unconditionally; only valid/ready are gated.
    assign s_araddr  = owner_q ? m1_araddr  : m0_araddr;
    assign s_arid    = owner_q ? m1_arid    : m0_arid;
    assign s_arlen   = owner_q ? m1_arlen   : m0_arlen;
    assign s_arsize  = owner_q ? m1_arsize  : m0_arsize;
    assign s_arburst = owner_q ? m1_arburst : m0_arburst;
    assign s_awaddr  = owner_q ? m1_awaddr  : m0_awaddr;
    assign s_awid    = owner_q ? m1_awid    : m0_awid;
    assign s_awlen   = owner_q ? m1_awlen   : m0_awlen;
    assign s_awsize  = owner_q ? m1_awsize  : m0_awsize;
    assign s_awburst = owner_q ? m1_awburst : m0_awburst;
    assign s_wdata   = owner_q ? m1_wdata   : m0_wdata;
    assign s_wstrb   = owner_q ? m1_wstrb   : m0_wstrb;
    assign s_wlast   = owner_q ? m1_wlast   : m0_wlast;

    assign s_arvalid = rd_a & (owner_q ? m1_arvalid : m0_arvalid);
    assign s_rready  = rd_d & (owner_q ? m1_rready : m0_rready);
    assign s_awvalid = aw_ok & (owner_q ? m1_awvalid : m0_awvalid);
    assign s_wvalid  = w_ok & (owner_q ? m1_wvalid : m0_wvalid);
    assign s_bready  = wr_b & (owner_q ? m1_bready : m0_bready);

    assign aw_ok = wr_a & ~aw_done_q;
    assign w_ok  = wr_a & ~w_done_q;

    assign m0_arready = rd_a & ~owner_q & s_arready;
    assign m1_arready = rd_a & owner_q & s_arready;
    assign m0_rvalid  = rd_d & ~owner_q & s_rvalid;
    assign m1_rvalid  = rd_d & owner_q & s_rvalid;
    assign m0_awready = aw_ok & ~owner_q & s_awready;
    assign m1_awready = aw_ok & owner_q & s_awready;
    assign m0_wready  = w_ok & ~owner_q & s_wready;
    assign m1_wready  = w_ok & owner_q & s_wready;
    assign m0_bvalid  = wr_b & ~owner_q & s_bvalid;
    assign m1_bvalid  = wr_b & owner_q & s_bvalid;

    assign m0_rdata = s_rdata;
    assign m1_rdata = s_rdata;
    assign m0_rresp = s_rresp;
    assign m1_rresp = s_rresp;
    assign m0_rlast = s_rlast;
    assign m1_rlast = s_rlast;
    assign m0_rid   = s_rid;
    assign m1_rid   = s_rid;
    assign m0_bresp = s_bresp;
    assign m1_bresp = s_bresp;
    assign m0_bid   = s_bid;
    assign m1_bid   = s_bid;

    assign ar_hs = s_arvalid & s_arready;
    assign r_hs  = s_rvalid & s_rready;
    assign aw_hs = s_awvalid & s_awready;
    assign w_hs  = s_wvalid & s_wready;
    assign b_hs  = s_bvalid & s_bready;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        win       = 1'b0;
        unique case (state_q)
            IDLE: begin
                // On a tie the master that did not hold the last grant wins.
                win = (req0 & req1) ? ~owner_q : req1;
                if (req0 | req1) begin
                    owner_d = win;
                    if (win ? m1_awvalid : m0_awvalid)
                        state_d = WR_A;
                    else
                        state_d = RD_A;
                end
            end
            RD_A: if (ar_hs) state_d = RD_D;
            RD_D: if (r_hs & s_rlast) state_d = IDLE;
            WR_A: begin
                aw_done_d = aw_done_q | aw_hs;
                w_done_d  = w_done_q | (w_hs & s_wlast);
                if (aw_done_d & w_done_d) begin
                    state_d   = WR_B;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            WR_B: if (b_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Watchdog restarts on any progress; saturates so it pulses once.
    assign evt     = (state_d != state_q) | ar_hs | r_hs
                   | aw_hs | w_hs | b_hs;
    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        cnt_d = cnt_q;
        tmo_d = 1'b0;
        if ((state_q == IDLE) || evt) begin
            cnt_d = '0;
        end else if (cnt_q != TMAX) begin
            cnt_d = cnt_inc;
            tmo_d = (TIMEOUT != 0) && (cnt_inc == TMAX);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            cnt_q     <= '0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
        end
    end

    assign o_busy    = (state_q != IDLE);
    assign o_owner   = owner_q;
    assign o_timeout = tmo_q;

endmodule

// File: tb/tb_axi_bus_arbiter.sv
// Bench for axi_bus_arbiter: reactive slave model, scoreboard of
// master-side responses, vector table plus multi-cycle sequences.
module tb_axi_bus_arbiter;

    localparam logic [31:0] KEY  = 32'h5EAD_BEEF;
    localparam logic [31:0] WKEY = 32'h0F0F_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        m_arvalid[2], m_arready[2];
    logic [31:0] m_araddr[2];
    logic [3:0]  m_arid[2];
    logic [7:0]  m_arlen[2];
    logic [2:0]  m_arsize[2];
    logic [1:0]  m_arburst[2];
    logic        m_rvalid[2], m_rready[2], m_rlast[2];
    logic [31:0] m_rdata[2];
    logic [1:0]  m_rresp[2];
    logic [3:0]  m_rid[2];
    logic        m_awvalid[2], m_awready[2];
    logic [31:0] m_awaddr[2];
    logic [3:0]  m_awid[2];
    logic [7:0]  m_awlen[2];
    logic [2:0]  m_awsize[2];
    logic [1:0]  m_awburst[2];
    logic        m_wvalid[2], m_wready[2], m_wlast[2];
    logic [31:0] m_wdata[2];
    logic [3:0]  m_wstrb[2];
    logic        m_bvalid[2], m_bready[2];
    logic [1:0]  m_bresp[2];
    logic [3:0]  m_bid[2];

    logic        s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
    logic [31:0] s_araddr, s_rdata, s_awaddr, s_wdata;
    logic [3:0]  s_arid, s_rid, s_awid, s_bid, s_wstrb;
    logic [7:0]  s_arlen, s_awlen;
    logic [2:0]  s_arsize, s_awsize;
    logic [1:0]  s_arburst, s_rresp, s_awburst, s_bresp;
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_wlast;
    logic        s_bvalid, s_bready;
    logic        busy, owner, tmo;

    axi_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .i_clk(clk), .i_rst(rst),
        .m0_arvalid(m_arvalid[0]), .m0_arready(m_arready[0]),
        .m0_araddr(m_araddr[0]), .m0_arid(m_arid[0]),
        .m0_arlen(m_arlen[0]), .m0_arsize(m_arsize[0]),
        .m0_arburst(m_arburst[0]),
        .m0_rvalid(m_rvalid[0]), .m0_rready(m_rready[0]),
        .m0_rdata(m_rdata[0]), .m0_rresp(m_rresp[0]),
        .m0_rlast(m_rlast[0]), .m0_rid(m_rid[0]),
        .m0_awvalid(m_awvalid[0]), .m0_awready(m_awready[0]),
        .m0_awaddr(m_awaddr[0]), .m0_awid(m_awid[0]),
        .m0_awlen(m_awlen[0]), .m0_awsize(m_awsize[0]),
        .m0_awburst(m_awburst[0]),
        .m0_wvalid(m_wvalid[0]), .m0_wready(m_wready[0]),
        .m0_wdata(m_wdata[0]), .m0_wstrb(m_wstrb[0]),
        .m0_wlast(m_wlast[0]),
        .m0_bvalid(m_bvalid[0]), .m0_bready(m_bready[0]),
        .m0_bresp(m_bresp[0]), .m0_bid(m_bid[0]),
        .m1_arvalid(m_arvalid[1]), .m1_arready(m_arready[1]),
        .m1_araddr(m_araddr[1]), .m1_arid(m_arid[1]),
        .m1_arlen(m_arlen[1]), .m1_arsize(m_arsize[1]),
        .m1_arburst(m_arburst[1]),
        .m1_rvalid(m_rvalid[1]), .m1_rready(m_rready[1]),
        .m1_rdata(m_rdata[1]), .m1_rresp(m_rresp[1]),
        .m1_rlast(m_rlast[1]), .m1_rid(m_rid[1]),
        .m1_awvalid(m_awvalid[1]), .m1_awready(m_awready[1]),
        .m1_awaddr(m_awaddr[1]), .m1_awid(m_awid[1]),
        .m1_awlen(m_awlen[1]), .m1_awsize(m_awsize[1]),
        .m1_awburst(m_awburst[1]),
        .m1_wvalid(m_wvalid[1]), .m1_wready(m_wready[1]),
        .m1_wdata(m_wdata[1]), .m1_wstrb(m_wstrb[1]),
        .m1_wlast(m_wlast[1]),
        .m1_bvalid(m_bvalid[1]), .m1_bready(m_bready[1]),
        .m1_bresp(m_bresp[1]), .m1_bid(m_bid[1]),
        .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_araddr(s_araddr), .s_arid(s_arid), .s_arlen(s_arlen),
        .s_arsize(s_arsize), .s_arburst(s_arburst),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
        .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rid(s_rid),
        .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_awaddr(s_awaddr), .s_awid(s_awid), .s_awlen(s_awlen),
        .s_awsize(s_awsize), .s_awburst(s_awburst),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_wlast(s_wlast),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .s_bid(s_bid),
        .o_busy(busy), .o_owner(owner), .o_timeout(tmo)
    );

    // Slave model: read data is (addr ^ KEY) + beat, B after AW and wlast.
    logic        ar_ok = 1'b1;
    int          aw_delay = 0;
    int          aw_wait;
    logic [1:0]  slv_rresp = 2'b00, slv_bresp = 2'b00;
    logic [31:0] r_addr;
    logic [7:0]  r_left, r_k;
    logic        aw_seen, wl_seen;
    logic [31:0] w_q[$];

    assign s_arready = ar_ok;
    assign s_awready = (aw_wait >= aw_delay);
    assign s_wready  = 1'b1;
    assign s_rdata   = (r_addr ^ KEY) + 32'(r_k);
    assign s_rlast   = (r_k == r_left);
    assign s_rresp   = slv_rresp;
    assign s_rid     = 4'd0;
    assign s_bresp   = slv_bresp;
    assign s_bid     = 4'd0;

    always @(posedge clk) begin
        if (rst) begin
            s_rvalid <= 1'b0;
            s_bvalid <= 1'b0;
            aw_seen  <= 1'b0;
            wl_seen  <= 1'b0;
            aw_wait  <= 0;
            r_addr   <= '0;
            r_left   <= '0;
            r_k      <= '0;
        end else begin
            if (s_arvalid && s_arready) begin
                r_addr   <= s_araddr;
                r_left   <= s_arlen;
                r_k      <= '0;
                s_rvalid <= 1'b1;
            end else if (s_rvalid && s_rready) begin
                if (r_k == r_left) s_rvalid <= 1'b0;
                else r_k <= r_k + 8'd1;
            end
            if (s_awvalid && !s_awready) aw_wait <= aw_wait + 1;
            if (s_awvalid && s_awready) begin
                aw_seen <= 1'b1;
                aw_wait <= 0;
            end
            if (s_wvalid && s_wready) begin
                w_q.push_back(s_wdata);
                if (s_wlast) wl_seen <= 1'b1;
            end
            if (!s_bvalid && aw_seen && wl_seen) begin
                s_bvalid <= 1'b1;
                aw_seen  <= 1'b0;
                wl_seen  <= 1'b0;
            end else if (s_bvalid && s_bready) begin
                s_bvalid <= 1'b0;
            end
        end
    end

    int checks = 0;
    int errors = 0;

    function automatic void chk(string name, logic [63:0] act,
                                logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    typedef struct {
        int          m;
        bit          b;
        logic [31:0] d;
        logic [1:0]  resp;
        bit          last;
    } exp_t;
    exp_t exp_q[$];

    function automatic void sb_pop(int m, bit b, logic [31:0] d,
                                   logic [1:0] resp, bit last);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected m=%0d b=%0d data=%0h", m, b, d);
        end else begin
            e = exp_q.pop_front();
            chk("sb_master", 64'(m), 64'(e.m));
            chk("sb_kind", 64'(b), 64'(e.b));
            chk("sb_resp", 64'(resp), 64'(e.resp));
            if (!b) begin
                chk("sb_rdata", 64'(d), 64'(e.d));
                chk("sb_rlast", 64'(last), 64'(e.last));
            end
        end
    endfunction

    function automatic void push_rd(int m, logic [31:0] a, int nb,
                                    int len, logic [1:0] resp);
        exp_t e;
        for (int k = 0; k < nb; k++) begin
            e.m = m; e.b = 1'b0; e.resp = resp;
            e.d = (a ^ KEY) + 32'(k);
            e.last = (k == len);
            exp_q.push_back(e);
        end
    endfunction

    function automatic void push_b(int m, logic [1:0] resp);
        exp_t e;
        e.m = m; e.b = 1'b1; e.d = '0; e.resp = resp; e.last = 1'b1;
        exp_q.push_back(e);
    endfunction

    // Monitor: samples on the falling edge, away from the active edge.
    int          cyc = 0;
    int          tmo_n = 0, tmo_cyc = 0, rise_cyc = 0, early_b = 0;
    logic        busy_p = 1'b0;
    logic [31:0] ar_seen_a, aw_seen_a;
    logic        aw_seen_own;
    logic        own_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (m_rvalid[m] && m_rready[m])
                sb_pop(m, 1'b0, m_rdata[m], m_rresp[m], m_rlast[m]);
            if (m_bvalid[m] && m_bready[m])
                sb_pop(m, 1'b1, 32'h0, m_bresp[m], 1'b1);
        end
        if (s_arvalid && s_arready) begin
            ar_seen_a <= s_araddr;
            own_q.push_back(owner);
        end
        if (s_awvalid && s_awready) begin
            aw_seen_a   <= s_awaddr;
            aw_seen_own <= owner;
        end
        if (s_bready && !s_bvalid && !(aw_seen && wl_seen))
            early_b <= early_b + 1;
        if (tmo) begin
            tmo_n   <= tmo_n + 1;
            tmo_cyc <= cyc;
        end
        if (busy && !busy_p) rise_cyc <= cyc;
        busy_p <= busy;
    end

    function automatic bit sig(int m, int w);
        case (w)
            0: return m_arready[m];
            1: return m_rvalid[m] && m_rlast[m];
            2: return m_awready[m];
            3: return m_wready[m];
            default: return m_bvalid[m];
        endcase
    endfunction

    task automatic wait_sig(int m, int w, int budget, string name);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!sig(m, w) && t < budget);
        if (!sig(m, w)) begin
            checks++;
            errors++;
            $display("FAIL %s wait expired after %0d cycles", name, t);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(int m, logic [31:0] a, logic [7:0] len);
        m_araddr[m]  = a;
        m_arlen[m]   = len;
        m_arsize[m]  = 3'd2;
        m_arburst[m] = 2'b01;
        m_arvalid[m] = 1'b1;
        wait_sig(m, 0, 100, "ar_wait");
        m_arvalid[m] = 1'b0;
        wait_sig(m, 1, 600, "rlast_wait");
    endtask

    task automatic do_write(int m, logic [31:0] a, logic [7:0] len,
                            int lead);
        m_awaddr[m]  = a;
        m_awlen[m]   = len;
        m_awsize[m]  = 3'd2;
        m_awburst[m] = 2'b01;
        fork
            begin
                if (lead > 0) begin
                    repeat (lead) @(posedge clk);
                    #1;
                end
                m_awvalid[m] = 1'b1;
                wait_sig(m, 2, 100, "aw_wait");
                m_awvalid[m] = 1'b0;
            end
            begin
                for (int k = 0; k <= int'(len); k++) begin
                    m_wdata[m]  = (a ^ WKEY) + 32'(k);
                    m_wstrb[m]  = 4'hF;
                    m_wlast[m]  = (k == int'(len));
                    m_wvalid[m] = 1'b1;
                    wait_sig(m, 3, 100, "w_wait");
                end
                m_wvalid[m] = 1'b0;
                m_wlast[m]  = 1'b0;
            end
        join
        wait_sig(m, 4, 100, "b_wait");
    endtask

    typedef struct {
        int          m;
        bit          wr;
        logic [31:0] a;
        logic [7:0]  len;
        logic [1:0]  resp;
        int          lead;
        int          awd;
        bit          exp_own;
    } vec_t;

    vec_t vt[6];

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{0, 1'b0, 32'h8000_0000, 8'd0,   2'b00, 0, 0, 1'b0};
        vt[1] = '{1, 1'b0, 32'h0000_1000, 8'd3,   2'b01, 0, 0, 1'b1};
        vt[2] = '{0, 1'b1, 32'h0000_2000, 8'd1,   2'b00, 0, 2, 1'b0};
        vt[3] = '{1, 1'b1, 32'h0000_3000, 8'd3,   2'b10, 2, 6, 1'b1};
        vt[4] = '{0, 1'b0, 32'h0000_4000, 8'd255, 2'b11, 0, 0, 1'b0};
        vt[5] = '{1, 1'b1, 32'h0000_5000, 8'd0,   2'b01, 0, 0, 1'b1};

        for (int m = 0; m < 2; m++) begin
            m_arvalid[m] = 0; m_araddr[m] = 0; m_arid[m] = 4'(m);
            m_arlen[m] = 0; m_arsize[m] = 0; m_arburst[m] = 0;
            m_awvalid[m] = 0; m_awaddr[m] = 0; m_awid[m] = 4'(m);
            m_awlen[m] = 0; m_awsize[m] = 0; m_awburst[m] = 0;
            m_wvalid[m] = 0; m_wdata[m] = 0; m_wstrb[m] = 0;
            m_wlast[m] = 0; m_rready[m] = 1; m_bready[m] = 1;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_owner", 64'(owner), 64'd0);
        chk("rst_timeout", 64'(tmo), 64'd0);
        chk("rst_s_valids", 64'({s_arvalid, s_awvalid, s_wvalid}), 64'd0);
        chk("rst_s_readys", 64'({s_rready, s_bready}), 64'd0);
        chk("rst_m_readys", 64'({m_arready[0], m_arready[1],
            m_awready[0], m_awready[1], m_wready[0], m_wready[1]}), 64'd0);
        rst = 1'b0;

        // Tie right after reset: owner is 0, so m1 goes first.
        push_rd(1, 32'h0000_0100, 1, 0, 2'b00);
        push_rd(0, 32'h0000_0200, 1, 0, 2'b00);
        own_q.delete();
        fork
            do_read(0, 32'h0000_0200, 8'd0);
            do_read(1, 32'h0000_0100, 8'd0);
        join
        chk("tie_grants", 64'(own_q.size()), 64'd2);
        if (own_q.size() == 2) begin
            chk("tie_first", 64'(own_q[0]), 64'd1);
            chk("tie_second", 64'(own_q[1]), 64'd0);
        end

        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            own_q.delete();
            w_q.delete();
            aw_delay = vt[i].awd;
            if (vt[i].wr) begin
                slv_bresp = vt[i].resp;
                push_b(vt[i].m, vt[i].resp);
                do_write(vt[i].m, vt[i].a, vt[i].len, vt[i].lead);
                chk("v_awaddr", 64'(aw_seen_a), 64'(vt[i].a));
                chk("v_aw_owner", 64'(aw_seen_own), 64'(vt[i].exp_own));
                chk("v_wbeats", 64'(w_q.size()), 64'(vt[i].len) + 1);
                for (int k = 0; k < w_q.size(); k++)
                    chk("v_wdata", 64'(w_q[k]),
                        64'((vt[i].a ^ WKEY) + 32'(k)));
            end else begin
                slv_rresp = vt[i].resp;
                push_rd(vt[i].m, vt[i].a, int'(vt[i].len) + 1,
                        int'(vt[i].len), vt[i].resp);
                do_read(vt[i].m, vt[i].a, vt[i].len);
                chk("v_araddr", 64'(ar_seen_a), 64'(vt[i].a));
                chk("v_ar_owner", 64'(own_q.size() > 0 ? own_q[$] : 1'bx),
                    64'(vt[i].exp_own));
            end
            chk("v_owner", 64'(owner), 64'(vt[i].exp_own));
            chk("v_idle", 64'(busy), 64'd0);
        end
        aw_delay  = 0;
        slv_rresp = 2'b00;
        slv_bresp = 2'b00;

        // m0 raises AW and AR together: the write is serviced first.
        push_b(0, 2'b00);
        push_rd(0, 32'h0000_7000, 2, 1, 2'b00);
        fork
            do_write(0, 32'h0000_6000, 8'd0, 0);
            do_read(0, 32'h0000_7000, 8'd1);
        join
        chk("both_idle", 64'(busy), 64'd0);

        // Slave withholds arready: a single timeout pulse 8 cycles in.
        ar_ok = 1'b0;
        push_rd(0, 32'h0000_9000, 1, 0, 2'b00);
        fork
            do_read(0, 32'h0000_9000, 8'd0);
            begin
                repeat (20) @(posedge clk);
                #1;
                chk("tmo_pulses", 64'(tmo_n), 64'd1);
                chk("tmo_delay", 64'(tmo_cyc - rise_cyc), 64'd8);
                chk("tmo_busy", 64'(busy), 64'd1);
                chk("tmo_owner", 64'(owner), 64'd0);
                ar_ok = 1'b1;
            end
        join

        // Reset while beat 2 of a 4-beat m1 burst is on the bus.
        push_rd(1, 32'h0000_A000, 2, 3, 2'b00);
        m_araddr[1] = 32'h0000_A000;
        m_arlen[1]  = 8'd3;
        m_arvalid[1] = 1'b1;
        wait_sig(1, 0, 100, "rst_ar_wait");
        m_arvalid[1] = 1'b0;
        begin
            int t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!(m_rvalid[1] &&
                m_rdata[1] == (32'h0000_A000 ^ KEY) + 32'd1) && t < 50);
            chk("rst_beat2_seen", 64'(m_rvalid[1]), 64'd1);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_owner", 64'(owner), 64'd0);
        chk("mid_timeout", 64'(tmo), 64'd0);
        chk("mid_s_valids", 64'({s_arvalid, s_awvalid, s_wvalid}), 64'd0);
        chk("mid_s_readys", 64'({s_rready, s_bready}), 64'd0);
        chk("mid_m_rvalid", 64'({m_rvalid[0], m_rvalid[1]}), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        push_rd(0, 32'h0000_B000, 1, 0, 2'b00);
        do_read(0, 32'h0000_B000, 8'd0);
        chk("post_rst_owner", 64'(owner), 64'd0);
        chk("post_rst_idle", 64'(busy), 64'd0);

        repeat (3) @(posedge clk);
        #1;
        chk("tmo_total", 64'(tmo_n), 64'd1);
        chk("early_bready", 64'(early_b), 64'd0);
        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_bus_arbiter.md
Name: axi_bus_arbiter

Overview:
- Two-master, one-slave AXI4 arbiter that shares the single memory/peripheral AXI port between the instruction fetch unit (m0) and the load/store unit (m1).
- Allows exactly one transaction (read or write) in flight on the slave side at a time.
- Routes the response back to the owning master.
- Sits between the core's bus masters and the slave-side crossbar, where the access-fault monitor also observes the slave-side channels.

Parameters:
- ADDR_W, 32, address width (matches CPU_WIDTH).
- DATA_W, 32, data width; strobe width is DATA_W/8.
- TIMEOUT, 255, cycles a granted transaction may wait on any single slave handshake before `o_timeout` pulses (0 disables).

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous active-high reset
- mN_arvalid/arready/araddr/arid/arlen/arsize/arburst  in/out/in/in/in/in/in  1/1/ADDR_W/4/8/3/2  per-master AR channel, N=0,1
- mN_rvalid/rready/rdata/rresp/rlast/rid  out/in/out/out/out/out  1/1/DATA_W/2/1/4  per-master R channel
- mN_awvalid/awready/awaddr/awid/awlen/awsize/awburst  in/out/in/in/in/in/in  as AR  per-master AW channel
- mN_wvalid/wready/wdata/wstrb/wlast  in/out/in/in/in  1/1/DATA_W/DATA_W/8/1  per-master W channel
- mN_bvalid/bready/bresp/bid  out/in/out/out  1/1/2/4  per-master B channel
- s_* (all five channels, same fields)  mirrored directions  slave-side AXI port
- o_busy  out  1  a transaction owns the slave port
- o_owner  out  1  current/last grant (0 = m0, 1 = m1)
- o_timeout  out  1  one-cycle pulse on handshake timeout

Behaviour:
- Clock and reset: one clock `i_clk`; reset `i_rst` is synchronous and active-high.
- Reset values:
  - state = IDLE, o_owner = 0, o_busy = 0, o_timeout = 0, timeout counter = 0.
  - All s_*valid, s_*ready, mN_*valid and mN_*ready = 0.
- States:
  - IDLE: no transaction owned.
  - RD_A: AR forwarded to the slave.
  - RD_D: R beats being returned.
  - WR_A: AW and W forwarded.
  - WR_B: awaiting the B response.
- Request: master N requests when mN_arvalid or mN_awvalid is high.
- Arbitration in IDLE:
  - Round-robin between masters; on a tie, the master other than o_owner wins.
  - Within the winning master, a write (awvalid) beats a read (arvalid).
  - Grant is registered: IDLE → RD_A or WR_A on the cycle after the request is sampled, and o_owner updates on the same edge.
- Grant/forwarding rules:
  - Only the owner's channels are muxed to s_*; the non-owner sees all readys = 0 and all response valids = 0.
  - Channels are combinational pass-through while owned (no extra latency after grant).
  - Requests are never dropped; a master must hold valid per AXI.
- RD_A → RD_D on s_arvalid && s_arready.
- RD_D:
  - Passes R beats to the owner.
  - Exits to IDLE on s_rvalid && s_rready && s_rlast.
- WR_A:
  - AW and W are forwarded independently; each completion is tracked with a sticky flag.
  - Moves to WR_B once the AW handshake has occurred and the W beat with wlast has handshaken; these may be the same cycle or in either order.
- WR_B → IDLE on s_bvalid && s_bready.
- Back-to-back: a new grant may be decided in the IDLE cycle immediately after a completion, giving a minimum 1 idle cycle between transactions.
- Bursts: arlen/awlen up to 255 are supported; the arbiter does not count beats and relies on rlast/wlast.
- Response codes: rresp/bresp are passed through unaltered; error handling is owned by the fault monitor.
- Timeout:
  - The counter resets on every state transition and on every slave-side handshake, and increments otherwise while not IDLE.
  - At TIMEOUT, o_timeout pulses for 1 cycle and the counter saturates; the state is unchanged.
- Reset mid-transaction:
  - Returns to IDLE immediately and deasserts all valids/readys.
  - The slave is assumed reset by the same i_rst.
- o_busy = (state != IDLE).

Test Plan:
- Single read: m0 ARADDR=0x8000_0000, arlen=0 → grant the cycle after arvalid; s_araddr=0x8000_0000; m0 receives rdata=0xDEADBEEF with rlast; m1_rvalid stays 0; state returns to IDLE.
- Simultaneous read requests from m0 and m1 after reset (o_owner=0) → m1 granted first, then m0; o_owner sequence 1,0; no overlap on s_arvalid.
- m1 write with awlen=3, W arriving 2 cycles before AW → 4 W beats forwarded, WR_B entered only after both AW and wlast; bresp=2'b10 delivered unchanged to m1.
- m0 holds both arvalid and awvalid → write serviced first, read granted after B completes.
- Slave never asserts arready with TIMEOUT=8 → o_timeout pulses exactly once, 8 cycles after entering RD_A; o_busy stays 1.
- i_rst asserted during RD_D beat 2 of 4 → next cycle state=IDLE, all outputs at reset values; a fresh m0 read then completes normally.
